// File: rtl/program_loader.sv
// Boot loader: assembles a little-endian byte image into instruction memory and then releases
// the core from reset. Optional trailer checksum enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int unsigned IMEM_DEPTH  = 256,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic                   imem_we,
   output logic [31:0]            imem_addr,
   output logic [31:0]            imem_wdata,
   output logic                   core_reset,
   output logic                   load_done,
   output logic                   load_error,
   output logic [COUNT_WIDTH-1:0] words_loaded
);

   typedef enum logic [2:0] {
      StCntLo,
      StCntHi,
      StData,
      StWrite,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck,
`endif
      StRun,
      StError
   } state_e;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam state_e StLoadEnd = StCheck;
`else
   localparam state_e StLoadEnd = StRun;
`endif

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] word_idx_q, word_idx_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [31:0]            shift_q, shift_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]             csum_q, csum_d;
`endif

   logic        accept;
   logic [15:0] hdr;

   assign accept = rx_valid && rx_ready;
   assign hdr    = {rx_data, count_q[7:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StCntLo;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      unique case (state_q)
         StCntLo: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d = '0;
`endif
            if (accept) begin
               count_d = COUNT_WIDTH'(rx_data);
               state_d = StCntHi;
            end
         end
         StCntHi: begin
            if (accept) begin
               count_d = COUNT_WIDTH'(hdr);
               if (32'(hdr) > IMEM_DEPTH) begin
                  state_d = StError;
               end else if (hdr == 16'h0000) begin
                  state_d = StLoadEnd;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               shift_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            word_idx_d = word_idx_q + 1'b1;
            state_d    = (word_idx_d == count_q) ? StLoadEnd : StData;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         StCheck: begin
            if (accept) begin
               state_d = (rx_data == csum_q) ? StRun : StError;
            end
         end
`endif
         StRun, StError: begin
            state_d = state_q;
         end
         default: begin
            state_d = StCntLo;
         end
      endcase
   end

   always_comb begin
      rx_ready     = 1'b0;
      imem_we      = 1'b0;
      core_reset   = 1'b1;
      load_done    = 1'b0;
      load_error   = 1'b0;
      imem_addr    = 32'(word_idx_q) << 2;
      imem_wdata   = shift_q;
      words_loaded = word_idx_q;
      unique case (state_q)
         StCntLo, StCntHi, StData: rx_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         StCheck: rx_ready = 1'b1;
`endif
         StWrite: imem_we = 1'b1;
         StRun: begin
            core_reset = 1'b0;
            load_done  = 1'b1;
         end
         StError: load_error = 1'b1;
         default: rx_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; checksum steps run when
// PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        load_done;
   logic        load_error;
   logic [15:0] words_loaded;

   int checks   = 0;
   int failures = 0;

   // Write log filled by the monitor below, cleared by reset.
   int          wr_cnt;
   logic [31:0] wr_addr [8];
   logic [31:0] wr_data [8];
   logic        wr_ready_bad;
   logic        wr_done_bad;

   program_loader #(
      .IMEM_DEPTH (256),
      .COUNT_WIDTH(16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .core_reset  (core_reset),
      .load_done   (load_done),
      .load_error  (load_error),
      .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset) begin
         wr_cnt       <= 0;
         wr_ready_bad <= 1'b0;
         wr_done_bad  <= 1'b0;
      end else if (imem_we) begin
         if (wr_cnt < 8) begin
            wr_addr[wr_cnt] <= imem_addr;
            wr_data[wr_cnt] <= imem_wdata;
         end
         wr_cnt <= wr_cnt + 1;
         if (rx_ready) wr_ready_bad <= 1'b1;
         if (load_done) wr_done_bad <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Returns 1 ns after the edge at which the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         failures++;
         $display("FAIL send_byte_timeout observed=no_ready expected=ready byte=0x%0h", b);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic rnd);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] tmp;
         tmp = w >> (8 * i);
         send_byte(tmp[7:0], rnd ? int'($urandom_range(0, 3)) : 0);
      end
   endtask

   // Called 1 ns into the WRITE cycle of the last word; returns in RUN.
   task automatic finish_image(input logic [7:0] trailer);
      @(posedge clk);
      #1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(trailer, 0);
`else
      if (trailer != trailer) $display("unreachable");
`endif
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset values
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_load_done", load_done, 0);
      chk("rst_load_error", load_error, 0);
      chk("rst_words", words_loaded, 0);

      // Single word
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'h0000_0013, 1'b0);
      chk("w1_we", imem_we, 1);
      chk("w1_addr", imem_addr, 32'h0);
      chk("w1_data", imem_wdata, 32'h13);
      chk("w1_ready_in_write", rx_ready, 0);
      chk("w1_core_reset_in_write", core_reset, 1);
      finish_image(8'h13);
      chk("w1_core_reset", core_reset, 0);
      chk("w1_done", load_done, 1);
      chk("w1_words", words_loaded, 1);
      chk("w1_ready", rx_ready, 0);
      chk("w1_we_off", imem_we, 0);
      @(negedge clk);
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      repeat (4) @(negedge clk);
      rx_valid = 1'b0;
      chk("w1_ignored_done", load_done, 1);
      chk("w1_ignored_words", words_loaded, 1);
      chk("w1_wr_cnt", wr_cnt, 1);

      // Three words with random gaps
      do_reset();
      send_byte(8'h03, 1);
      send_byte(8'h00, 2);
      send_word(32'h0050_0093, 1'b1);
      send_byte(8'h13, 0);
      chk("w3_words_after_first", words_loaded, 1);
      send_byte(8'h01, int'($urandom_range(0, 3)));
      send_byte(8'hA0, int'($urandom_range(0, 3)));
      send_byte(8'h00, int'($urandom_range(0, 3)));
      chk("w3_done_early", load_done, 0);
      send_word(32'h0020_81B3, 1'b1);
      chk("w3_done_before_last_write", load_done, 0);
      finish_image(8'h63);
      chk("w3_done", load_done, 1);
      chk("w3_words", words_loaded, 3);
      chk("w3_wr_cnt", wr_cnt, 3);
      chk("w3_addr0", wr_addr[0], 32'h0);
      chk("w3_data0", wr_data[0], 32'h0050_0093);
      chk("w3_addr1", wr_addr[1], 32'h4);
      chk("w3_data1", wr_data[1], 32'h00A0_0113);
      chk("w3_addr2", wr_addr[2], 32'h8);
      chk("w3_data2", wr_data[2], 32'h0020_81B3);
      chk("w3_ready_in_write", wr_ready_bad, 0);
      chk("w3_done_in_write", wr_done_bad, 0);

      // Zero count
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk("z_check_ready", rx_ready, 1);
      chk("z_check_done", load_done, 0);
      send_byte(8'h00, 0);
`endif
      chk("z_done", load_done, 1);
      chk("z_core_reset", core_reset, 0);
      chk("z_words", words_loaded, 0);
      repeat (3) @(negedge clk);
      chk("z_wr_cnt", wr_cnt, 0);

      // Oversize count 257
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      chk("ov_error", load_error, 1);
      chk("ov_core_reset", core_reset, 1);
      chk("ov_ready", rx_ready, 0);
      chk("ov_done", load_done, 0);
      @(negedge clk);
      rx_valid = 1'b1;
      repeat (5) @(negedge clk);
      rx_valid = 1'b0;
      chk("ov_hold_error", load_error, 1);
      chk("ov_wr_cnt", wr_cnt, 0);

      // Count exactly at capacity is accepted
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      chk("cap_error", load_error, 0);
      chk("cap_ready", rx_ready, 1);
      chk("cap_done", load_done, 0);

      // Reset mid-word
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      do_reset();
      chk("mid_rx_ready", rx_ready, 1);
      chk("mid_core_reset", core_reset, 1);
      chk("mid_words", words_loaded, 0);
      chk("mid_wdata", imem_wdata, 0);
      chk("mid_addr", imem_addr, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'h1234_5678, 1'b0);
      finish_image(8'h08);
      chk("mid_done", load_done, 1);
      chk("mid_wr_cnt", wr_cnt, 1);
      chk("mid_wr_addr", wr_addr[0], 32'h0);
      chk("mid_wr_data", wr_data[0], 32'h1234_5678);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Good and bad trailer
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'h0000_0013, 1'b0);
      finish_image(8'h13);
      chk("ck_good_done", load_done, 1);
      chk("ck_good_error", load_error, 0);
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'h0000_0013, 1'b0);
      finish_image(8'h14);
      chk("ck_bad_error", load_error, 1);
      chk("ck_bad_core_reset", core_reset, 1);
      chk("ck_bad_done", load_done, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the processor core and its instruction memory.
- Receives a byte stream on a valid/ready interface, assembles 32-bit little-endian instruction words, and writes them sequentially into instruction memory from address 0.
- Holds the core in reset until the whole image is written, then releases it.
- Sits between the host byte link (UART receiver or testbench) and the instruction memory write port / core reset input.

Parameters:
- IMEM_DEPTH, 256, instruction memory capacity in 32-bit words; largest word count accepted.
- COUNT_WIDTH, 16, width of the header word count and of words_loaded.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write strobe, one-cycle pulse per word
- imem_addr  output  32  byte address of the write, word aligned (word_idx*4)
- imem_wdata  output  32  assembled instruction word
- core_reset  output  1  reset to the processor core, high while loading or on error
- load_done  output  1  image loaded, core running
- load_error  output  1  bad header (or checksum, when enabled)
- words_loaded  output  COUNT_WIDTH  count of words written so far

Behaviour:
- Interface:
  - One clock, clk. Reset is synchronous, active-high, named reset.
  - A byte transfers at a rising edge where rx_valid && rx_ready. The source must hold rx_data stable while rx_valid && !rx_ready.
- Reset values:
  - State CNT_LO, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_reset=1, load_done=0, load_error=0, words_loaded=0.
  - Byte index=0, word index=0.
  - Instruction memory contents are not touched.
- Image format: count low byte, count high byte, then count×4 payload bytes, least significant byte of each word first.
- States:
  - CNT_LO: accept byte into count[7:0] -> CNT_HI.
  - CNT_HI: accept byte into count[15:8], then branch on the full count:
    - count > IMEM_DEPTH -> ERROR.
    - count == 0 -> RUN (or CHECK if CHECKSUM_EN).
    - otherwise -> DATA.
  - DATA: each accepted byte fills byte lane byte_idx of the shift word; byte_idx increments 0..3. On the 4th byte -> WRITE, byte_idx wraps to 0.
  - WRITE: one cycle.
    - imem_we=1, imem_addr=word_idx*4, imem_wdata=assembled word, rx_ready=0.
    - Next edge: word_idx++ and words_loaded++.
    - If the new word_idx == count -> RUN (or CHECK); otherwise -> DATA.
  - RUN: core_reset=0, load_done=1, rx_ready=0. Further bytes are ignored (never accepted). Terminal until reset.
  - ERROR: core_reset=1, load_error=1, rx_ready=0. Terminal until reset.
- rx_ready is 1 in CNT_LO, CNT_HI, DATA and CHECK; 0 elsewhere.
- Outputs are registered. imem_we is 0 in every state except WRITE.
- Latency:
  - 4th byte of a word accepted at edge N -> imem_we high during cycle N..N+1.
  - If that was the last word, the state is RUN after edge N+1, so core_reset=0 and load_done=1 from then on.
- rx_valid gaps are allowed anywhere; the FSM simply waits.
- Reset mid-load:
  - Immediate return to reset values; partial word and count are discarded.
  - Words already written remain in memory. A fresh header is required.
- word_idx never exceeds count, and count ≤ IMEM_DEPTH, so addresses stay within memory; no wrap-around.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With it defined:
  - A running XOR of all payload bytes is kept; it is cleared at reset and in CNT_LO.
  - After the last word (or after the header when count == 0) the FSM enters CHECK and accepts one trailer byte.
  - Trailer equal to the running XOR -> RUN; otherwise -> ERROR.
  - Header bytes are excluded from the XOR.
- Without it: no CHECK state, no checksum logic, and no trailer byte is expected. A trailer byte sent anyway is ignored in RUN.

Test Plan:
- Single word: bytes 01 00 13 00 00 00 -> exactly one imem_we pulse with addr 0x0, data 0x00000013. Next cycle core_reset=0, load_done=1, words_loaded=1, rx_ready=0.
- Three words with random 0–3 cycle rx_valid gaps: 03 00, then words 0x00500093, 0x00A00113, 0x002081B3 -> writes at addr 0x0, 0x4, 0x8 with those data values. rx_ready=0 exactly in each WRITE cycle; load_done only after the third write.
- Zero count: bytes 00 00 -> no imem_we. RUN (load_done=1, core_reset=0) immediately after the second byte's edge; with checksum enabled, after a 00 trailer.
- Oversize: bytes 01 01 (count 257 > IMEM_DEPTH 256) -> ERROR. load_error=1, core_reset=1, rx_ready=0, no writes; holds until reset.
- Reset mid-word: header 01 00, bytes AA BB, then reset for one cycle -> all outputs at reset values. Then 01 00 78 56 34 12 -> single write addr 0x0, data 0x12345678; AA/BB do not appear.
- Checksum (PROGRAM_LOADER_CHECKSUM_EN): 01 00 13 00 00 00, trailer 13 -> load_done=1. The same image with trailer 14 -> load_error=1, core_reset stays 1.
